// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register offsets and warm-up length.
package gpio_pkg;

  localparam logic [12:0] GPI_A = 13'h00;
  localparam logic [12:0] GPO_A = 13'h01;
  localparam logic [12:0] DIR_A = 13'h02;
  localparam logic [12:0] IE_A  = 13'h03;
  localparam logic [12:0] IP_A  = 13'h04;
  localparam logic [12:0] POL_A = 13'h05;
  localparam logic [12:0] SET_A = 13'h06;
  localparam logic [12:0] CLR_A = 13'h07;

  // Edges are masked until the synchroniser and the edge-detect flop hold real pad data.
  function automatic int warmup_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/gpio_in_filt.sv
// Pad input synchroniser with optional debounce filter (enabled by GPIO_DEBOUNCE_EN).
module gpio_in_filt #(
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_DIV     = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] flt
);

  logic [SYNC_STAGES-1:0][DW-1:0] sync_reg;
  logic [DW-1:0]                  syn;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign syn = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [CW-1:0]        div_reg;
  logic                 tick;
  logic [2:0][DW-1:0]   hist_reg;
  logic [DW-1:0]        agree;
  logic [DW-1:0]        flt_reg;

  assign tick  = (div_reg == CW'(DEB_DIV - 1));
  // A bit is accepted only when its three most recent samples are identical.
  assign agree = ~(hist_reg[0] ^ hist_reg[1]) & ~(hist_reg[1] ^ hist_reg[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= '0;
      hist_reg <= '0;
      flt_reg  <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (tick) begin
        hist_reg <= {hist_reg[1:0], syn};
      end
      flt_reg <= (flt_reg & ~agree) | (hist_reg[0] & agree);
    end
  end

  assign flt = flt_reg;
`else
  assign flt = syn;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: direction, atomic set/clear, edge interrupts with W1C pending bits.
// Define GPIO_DEBOUNCE_EN to insert the debounce filter on the input path.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 13,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_DIV     = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic [DW-1:0] gpio_oe,
  output logic          irq
);

  localparam int WU = warmup_len(SYNC_STAGES);
  localparam int WW = $clog2(WU + 1);

  logic [DW-1:0] flt;
  logic [DW-1:0] prev_reg;
  logic [DW-1:0] gpo_reg;
  logic [DW-1:0] dir_reg;
  logic [DW-1:0] ie_reg;
  logic [DW-1:0] ip_reg;
  logic [DW-1:0] pol_reg;
  logic [DW-1:0] dout_reg;
  logic [WW-1:0] wu_reg;
  logic          warm;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic [DW-1:0] edge_det;
  logic [DW-1:0] w1c;
  logic [DW-1:0] rd_data;

  gpio_in_filt #(
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_DIV     (DEB_DIV)
  ) u_filt (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .flt     (flt)
  );

  assign warm = (wu_reg == WW'(WU));
  assign rise = flt & ~prev_reg;
  assign fall = ~flt & prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_edge
      assign edge_det[gi] = pol_reg[gi] ? rise[gi] : fall[gi];
    end
  endgenerate

  assign w1c = (we && (addr == AW'(IP_A))) ? din : '0;

  always_comb begin
    rd_data = '0;
    case (addr)
      AW'(GPI_A): rd_data = flt;
      AW'(GPO_A): rd_data = gpo_reg;
      AW'(DIR_A): rd_data = dir_reg;
      AW'(IE_A):  rd_data = ie_reg;
      AW'(IP_A):  rd_data = ip_reg;
      AW'(POL_A): rd_data = pol_reg;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= '0;
      gpo_reg  <= '0;
      dir_reg  <= '0;
      ie_reg   <= '0;
      ip_reg   <= '0;
      pol_reg  <= '0;
      dout_reg <= '0;
      wu_reg   <= '0;
    end else begin
      prev_reg <= flt;
      if (!warm) begin
        wu_reg <= wu_reg + 1'b1;
      end
      // A new edge overrides a same-cycle clear on that bit.
      ip_reg <= (ip_reg & ~w1c) | (warm ? edge_det : '0);
      if (we) begin
        case (addr)
          AW'(GPO_A): gpo_reg <= din;
          AW'(DIR_A): dir_reg <= din;
          AW'(IE_A):  ie_reg  <= din;
          AW'(POL_A): pol_reg <= din;
          AW'(SET_A): gpo_reg <= gpo_reg | din;
          AW'(CLR_A): gpo_reg <= gpo_reg & ~din;
          default: ;
        endcase
      end else begin
        dout_reg <= rd_data;
      end
    end
  end

  assign dout     = dout_reg;
  assign gpio_out = gpo_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = |(ip_reg & ie_reg);

endmodule
